// File: rtl/score_display.sv
// Per-player BCD score counter rendered as NUM_DIGITS seven-segment digits on the VGA raster.
// Optional macro SCORE_BLINK_EN blinks the digits for BLINK_FRAMES frames after each score change.

module score_digit #(
  parameter int X0      = 330,
  parameter int Y0      = 50,
  parameter int DIGIT_W = 30,
  parameter int DIGIT_H = 50,
  parameter int SEG_T   = 5
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [9:0] cx,
  input  logic [8:0] cy,
  input  logic [9:0] xoff,
  input  logic [3:0] nib,
  input  logic       blank,
  output logic       lit
);
  localparam logic signed [11:0] X0S  = 12'(X0);
  localparam logic signed [11:0] Y0S  = 12'(Y0);
  localparam logic signed [11:0] ZERO = 12'sd0;
  localparam logic signed [11:0] W    = 12'(DIGIT_W);
  localparam logic signed [11:0] H    = 12'(DIGIT_H);
  localparam logic signed [11:0] T    = 12'(SEG_T);
  localparam logic signed [11:0] WR   = 12'(DIGIT_W - SEG_T);
  localparam logic signed [11:0] HD   = 12'(DIGIT_H - SEG_T);
  localparam logic signed [11:0] H2   = 12'(DIGIT_H / 2);
  localparam logic signed [11:0] G0   = 12'(DIGIT_H / 2 - SEG_T / 2);
  localparam logic signed [11:0] G1   = 12'(DIGIT_H / 2 - SEG_T / 2 + SEG_T);

  logic signed [11:0] bx, rx, ry;
  logic               in_cell, upper, left, right;
  logic [6:0]         seg_d, seg_q, pat_d, pat_q;

  // seg/pat bit order is {g,f,e,d,c,b,a}
  always_comb begin
    bx      = X0S + $signed({{2{xoff[9]}}, xoff});
    rx      = $signed({2'b00, cx}) - bx;
    ry      = $signed({3'b000, cy}) - Y0S;
    in_cell = (rx >= ZERO) && (rx < W) && (ry >= ZERO) && (ry < H);
    upper   = ry < H2;
    left    = rx < T;
    right   = rx >= WR;
    seg_d[0] = in_cell && (ry < T);
    seg_d[1] = in_cell && right && upper;
    seg_d[2] = in_cell && right && !upper;
    seg_d[3] = in_cell && (ry >= HD);
    seg_d[4] = in_cell && left && !upper;
    seg_d[5] = in_cell && left && upper;
    seg_d[6] = in_cell && (ry >= G0) && (ry < G1);
  end

  always_comb begin
    case (nib)
      4'd0:    pat_d = 7'h3F;
      4'd1:    pat_d = 7'h06;
      4'd2:    pat_d = 7'h5B;
      4'd3:    pat_d = 7'h4F;
      4'd4:    pat_d = 7'h66;
      4'd5:    pat_d = 7'h6D;
      4'd6:    pat_d = 7'h7D;
      4'd7:    pat_d = 7'h07;
      4'd8:    pat_d = 7'h7F;
      4'd9:    pat_d = 7'h6F;
      default: pat_d = 7'h00;
    endcase
    if (blank) pat_d = 7'h00;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      pat_q <= '0;
    end else begin
      seg_q <= seg_d;
      pat_q <= pat_d;
    end
  end

  assign lit = |(seg_q & pat_q);
endmodule

module score_display #(
  parameter int NUM_DIGITS   = 2,
  parameter int MAX_SCORE    = 11,
  parameter int X_ORIGIN     = 330,
  parameter int Y_ORIGIN     = 50,
  parameter int DIGIT_W      = 30,
  parameter int DIGIT_H      = 50,
  parameter int SEG_T        = 5,
  parameter int DIGIT_GAP    = 10,
  parameter int BLINK_FRAMES = 60
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [9:0]              CounterX,
  input  logic [8:0]              CounterY,
  input  logic [9:0]              xOffset,
  input  logic                    score_inc,
  input  logic                    score_clr,
  output logic                    scoreOut,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic                    win
);
  function automatic logic [4*NUM_DIGITS-1:0] to_bcd(input int v);
    int t;
    t = v;
    to_bcd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      to_bcd[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
  endfunction

  localparam logic [4*NUM_DIGITS-1:0] MAX_BCD = to_bcd(MAX_SCORE);

  logic [4*NUM_DIGITS-1:0] score_d, score_q;
  logic                    win_d, win_q;
  logic                    score_out_d, score_out_q;
  logic                    carry, zrun, mask;
  logic [NUM_DIGITS-1:0]   blank, lit;

  always_comb begin
    score_d = score_q;
    carry   = 1'b1;
    if (score_clr) begin
      score_d = '0;
    end else if (score_inc && score_q != MAX_BCD) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (carry) begin
          if (score_q[4*i +: 4] >= 4'd9) begin
            score_d[4*i +: 4] = 4'd0;
          end else begin
            score_d[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    win_d = (score_d == MAX_BCD);
  end

  // display index k=0 is the most significant nibble
  always_comb begin
    zrun  = 1'b1;
    blank = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zrun     = zrun && (score_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      blank[k] = zrun && (k != NUM_DIGITS - 1);
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    score_digit #(
      .X0     (X_ORIGIN + k * (DIGIT_W + DIGIT_GAP)),
      .Y0     (Y_ORIGIN),
      .DIGIT_W(DIGIT_W),
      .DIGIT_H(DIGIT_H),
      .SEG_T  (SEG_T)
    ) u_dig (
      .clock(clock),
      .rst_n(rst_n),
      .cx   (CounterX),
      .cy   (CounterY),
      .xoff (xOffset),
      .nib  (score_q[4*(NUM_DIGITS-1-k) +: 4]),
      .blank(blank[k]),
      .lit  (lit[k])
    );
  end

`ifdef SCORE_BLINK_EN
  localparam int BW = ($clog2(BLINK_FRAMES + 1) < 4) ? 4 : $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_d, blink_q;
  logic          bumped, frame_start;

  always_comb begin
    bumped      = score_inc && !score_clr && (score_q != MAX_BCD);
    frame_start = (CounterX == 10'd0) && (CounterY == 9'd0);
    blink_d     = blink_q;
    if (score_clr)                            blink_d = '0;
    else if (bumped)                          blink_d = BW'(BLINK_FRAMES);
    else if (frame_start && blink_q != '0)    blink_d = blink_q - BW'(1);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) blink_q <= '0;
    else        blink_q <= blink_d;
  end

  assign mask = (blink_q != '0) && blink_q[3];
`else
  logic [7:0] blink_unused;
  assign blink_unused = 8'(BLINK_FRAMES);
  assign mask = 1'b0;
`endif

  assign score_out_d = (|lit) && !mask;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      score_q     <= '0;
      win_q       <= 1'b0;
      score_out_q <= 1'b0;
    end else begin
      score_q     <= score_d;
      win_q       <= win_d;
      score_out_q <= score_out_d;
    end
  end

  assign scoreOut  = score_out_q;
  assign score_bcd = score_q;
  assign win       = win_q;
endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display at default parameters (units cell cols 370..399, tens 330..359, rows 50..99).

module tb_score_display;
  logic       clock = 1'b0;
  logic       rst_n;
  logic [9:0] CounterX;
  logic [8:0] CounterY;
  logic [9:0] xOffset;
  logic       score_inc, score_clr;
  logic       scoreOut;
  logic [7:0] score_bcd;
  logic       win;

  int n_chk = 0;
  int n_bad = 0;

  score_display dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .CounterX (CounterX),
    .CounterY (CounterY),
    .xOffset  (xOffset),
    .score_inc(score_inc),
    .score_clr(score_clr),
    .scoreOut (scoreOut),
    .score_bcd(score_bcd),
    .win      (win)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    CounterX = 10'(x);
    CounterY = 9'(y);
    tick();
    tick();
  endtask

  task automatic inc_n(input int n);
    for (int i = 0; i < n; i++) begin
      score_inc = 1'b1;
      tick();
      score_inc = 1'b0;
    end
  endtask

  task automatic clr();
    score_clr = 1'b1;
    tick();
    score_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; score_inc = 1'b0; score_clr = 1'b0;
    CounterX = 10'd5; CounterY = 9'd5; xOffset = 10'd0;
    tick(); tick();
    chk("rst_out", 32'(scoreOut), 32'd0);
    chk("rst_bcd", 32'(score_bcd), 32'h00);
    chk("rst_win", 32'(win), 32'd0);
    rst_n = 1'b1;
    tick();

    // score 1: units digit shows b,c only; tens blanked
    inc_n(1);
    chk("bcd_1", 32'(score_bcd), 32'h01);
    pix(397, 52); chk("one_b", 32'(scoreOut), 32'd1);
    pix(372, 52); chk("one_af", 32'(scoreOut), 32'd0);
    pix(332, 52); chk("lead_blank", 32'(scoreOut), 32'd0);
    pix(365, 52); chk("gap", 32'(scoreOut), 32'd0);
    pix(397, 75); chk("one_c", 32'(scoreOut), 32'd1);

    // carry into tens
    inc_n(9);
    chk("bcd_10", 32'(score_bcd), 32'h10);
    chk("win_10", 32'(win), 32'd0);
    pix(357, 52); chk("tens_b", 32'(scoreOut), 32'd1);
    pix(332, 52); chk("tens_af", 32'(scoreOut), 32'd0);
    pix(385, 75); chk("zero_g", 32'(scoreOut), 32'd0);
    pix(372, 52); chk("zero_a", 32'(scoreOut), 32'd1);

    // saturation at 11
    inc_n(1);
    chk("bcd_11", 32'(score_bcd), 32'h11);
    chk("win_11", 32'(win), 32'd1);
    inc_n(2);
    chk("bcd_sat", 32'(score_bcd), 32'h11);
    chk("win_sat", 32'(win), 32'd1);

    clr();
    chk("clr_bcd", 32'(score_bcd), 32'h00);
    chk("clr_win", 32'(win), 32'd0);
    pix(372, 52); chk("lsd_noblank", 32'(scoreOut), 32'd1);

    // clear wins over increment
    inc_n(7);
    chk("bcd_7", 32'(score_bcd), 32'h07);
    score_inc = 1'b1; score_clr = 1'b1;
    tick();
    score_inc = 1'b0; score_clr = 1'b0;
    chk("prio_bcd", 32'(score_bcd), 32'h00);
    chk("prio_win", 32'(win), 32'd0);

    // negative offset shifts units cell to cols 350..379
    inc_n(1);
    xOffset = 10'h3EC;
    pix(377, 52); chk("xoff_new", 32'(scoreOut), 32'd1);
    pix(397, 52); chk("xoff_old", 32'(scoreOut), 32'd0);
    xOffset = 10'd0;

    // asynchronous reset mid-raster with score 5 on a lit pixel
    inc_n(4);
    chk("bcd_5", 32'(score_bcd), 32'h05);
    pix(372, 52); chk("five_a", 32'(scoreOut), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("arst_out", 32'(scoreOut), 32'd0);
    chk("arst_bcd", 32'(score_bcd), 32'h00);
    chk("arst_win", 32'(win), 32'd0);
    #1 rst_n = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_bcd", 32'(score_bcd), 32'h00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
